// File: rtl/dram_rr_arbiter_pkg.sv
// Shared types for the round-robin RAM arbiter: state encoding, requester tags
// and the read-return pipeline record.
package dram_rr_arbiter_pkg;

  // Widest supported configuration; per-core vectors are padded to this width
  // so a 3-bit tag indexes them exactly.
  localparam int MAX_CORES = 8;
  localparam int TAG_W     = 3;
  localparam int HOLD_W    = 4;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [HOLD_W-1:0] hold_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } rd_tag_t;

  function automatic logic [MAX_CORES-1:0] tag_onehot(tag_t t);
    return MAX_CORES'(1) << t;
  endfunction

endpackage

// File: rtl/dram_rr_arbiter_if.sv
// Core-side request buses plus the RAM macro port, grouped so the arbiter
// sees one bundle.
interface dram_rr_arbiter_if #(
  parameter int NCORES = 2,
  parameter int AW     = 8,
  parameter int DW     = 8
) ();

  logic [NCORES-1:0]    rden;
  logic [NCORES-1:0]    wren;
  logic [NCORES*AW-1:0] Address;
  logic [NCORES*DW-1:0] Din;
  logic [DW-1:0]        RAMq;

  logic [NCORES-1:0]    acq;
  logic [NCORES*DW-1:0] Dq;
  logic [NCORES-1:0]    dvalid;
  logic [AW-1:0]        RAMAddress;
  logic [DW-1:0]        RAMDin;
  logic                 RAMwren;

  modport slave (
    input  rden, wren, Address, Din, RAMq,
    output acq, Dq, dvalid, RAMAddress, RAMDin, RAMwren
  );

  modport master (
    output rden, wren, Address, Din, RAMq,
    input  acq, Dq, dvalid, RAMAddress, RAMDin, RAMwren
  );

endinterface

// File: rtl/dram_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after `last`, wrapping
// around, with `last` itself checked at lowest priority.
module dram_rr_arbiter_rr_pick
  import dram_rr_arbiter_pkg::*;
#(
  parameter int NCORES = 2
) (
  input  logic [NCORES-1:0] req,
  input  tag_t              last,
  output tag_t              winner,
  output logic              any
);

  logic [MAX_CORES-1:0] req_pad;

  assign req_pad = MAX_CORES'(req);

  // NOTE: winner and any are assigned before the loop, so no path through this
  // block leaves them unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    // Scan farthest-first so the nearest request after `last` overwrites the rest.
    for (int i = NCORES; i >= 1; i--) begin
      if (req_pad[tag_t'((int'(last) + i) % NCORES)]) begin
        winner = tag_t'((int'(last) + i) % NCORES);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_rr_arbiter.sv
// Round-robin owner of a single-port 1-cycle-latency RAM shared by NCORES
// requesters, with bounded hold time and tagged read return.
module dram_rr_arbiter
  import dram_rr_arbiter_pkg::*;
#(
  parameter int NCORES   = 2,
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input logic              CLK,
  input logic              rst,
  dram_rr_arbiter_if.slave bus
);

  state_e  state_q, state_d;
  tag_t    owner_q, owner_d;
  tag_t    last_q, last_d;
  hold_t   hold_q, hold_d;
  rd_tag_t rd_q, rd_d;

  logic [NCORES-1:0]    acq_q, acq_d;
  logic [NCORES-1:0]    dvalid_q, dvalid_d;
  logic [NCORES*DW-1:0] dq_q;

  logic [NCORES-1:0]    req;
  logic [MAX_CORES-1:0] req_pad, rden_pad, wren_pad;
  logic [AW-1:0]        addr_arr [MAX_CORES];
  logic [DW-1:0]        din_arr  [MAX_CORES];

  tag_t pick_winner;
  logic pick_any;
  logic others;
  logic release_own;
  logic own;

  assign req      = bus.rden | bus.wren;
  assign req_pad  = MAX_CORES'(req);
  assign rden_pad = MAX_CORES'(bus.rden);
  assign wren_pad = MAX_CORES'(bus.wren);

  for (genvar i = 0; i < MAX_CORES; i++) begin : g_slice
    if (i < NCORES) begin : g_used
      assign addr_arr[i] = bus.Address[i*AW +: AW];
      assign din_arr[i]  = bus.Din[i*DW +: DW];
    end else begin : g_pad
      assign addr_arr[i] = '0;
      assign din_arr[i]  = '0;
    end
  end

  // While owning, last_q equals owner_q, so one picker serves both the idle
  // arbitration and the hand-over from the current owner.
  dram_rr_arbiter_rr_pick #(.NCORES(NCORES)) u_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  assign own         = (state_q == ST_OWN);
  assign others      = |(req_pad & ~tag_onehot(owner_q));
  assign release_own = ~req_pad[owner_q] | ((hold_q == hold_t'(MAX_HOLD)) & others);

  assign bus.RAMAddress = own ? addr_arr[owner_q] : '0;
  assign bus.RAMDin     = own ? din_arr[owner_q]  : '0;
  assign bus.RAMwren    = own & wren_pad[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    rd_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_OWN;
          owner_d = pick_winner;
          last_d  = pick_winner;
          hold_d  = hold_t'(1);
        end
      end
      ST_OWN: begin
        rd_d.valid = rden_pad[owner_q] & ~wren_pad[owner_q];
        rd_d.tag   = owner_q;
        if (release_own) begin
          if (pick_any) begin
            owner_d = pick_winner;
            last_d  = pick_winner;
            hold_d  = hold_t'(1);
          end else begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end
        end else if (hold_q != hold_t'(MAX_HOLD)) begin
          hold_d = hold_q + hold_t'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acq_d    = '0;
    dvalid_d = '0;
    for (int i = 0; i < NCORES; i++) begin
      acq_d[i]    = (state_d == ST_OWN) && (owner_d == tag_t'(i));
      dvalid_d[i] = rd_q.valid && (rd_q.tag == tag_t'(i));
    end
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      last_q   <= tag_t'(NCORES - 1);
      hold_q   <= '0;
      rd_q     <= '0;
      acq_q    <= '0;
      dvalid_q <= '0;
      // NOTE: Dq is a bank of ordinary output flops, not a memory macro, so it
      // can and does take part in reset.
      dq_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      rd_q     <= rd_d;
      acq_q    <= acq_d;
      dvalid_q <= dvalid_d;
      for (int i = 0; i < NCORES; i++) begin
        if (dvalid_d[i]) dq_q[i*DW +: DW] <= bus.RAMq;
      end
    end
  end

  assign bus.acq    = acq_q;
  assign bus.dvalid = dvalid_q;
  assign bus.Dq     = dq_q;

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// Randomised and directed bench for dram_rr_arbiter with a behavioural
// ownership model, a reference memory and a read-return scoreboard.
module tb_dram_rr_arbiter;

  localparam int NC  = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int MH  = 4;
  localparam int WAIT_BOUND = (NC - 1) * MH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_rr_arbiter_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus ();

  dram_rr_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus)
  );

  bit [7:0] ram [256];
  always @(posedge clk) begin
    if (bus.RAMwren === 1'b1) ram[bus.RAMAddress] <= bus.RAMDin;
    bus.RAMq <= ram[bus.RAMAddress];
  end

  typedef struct {
    int       tag;
    logic [7:0] data;
    int       due;
  } exp_t;

  exp_t     sb_q [$];
  int       checks = 0;
  int       errors = 0;
  int       edge_cnt = 0;
  int       dv_cnt [NC];
  logic [7:0] exp_dq [NC];

  bit [7:0] ref_mem [256];
  bit       m_own;
  int       m_owner, m_last, m_hold;

  bit       pend [NC];
  bit       p_rd [NC], p_wr [NC];
  logic [7:0] p_addr [NC], p_din [NC];
  logic     rst_next;
  int       wait_cnt [NC];
  int       max_wait = 0;
  int       wren_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic int rr_next(input int from, input logic [NC-1:0] r);
    for (int k = 1; k <= NC; k++) begin
      if (r[(from + k) % NC]) return (from + k) % NC;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NC; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: every edge, retire the read due at this edge and compare outputs.
  initial begin
    logic       rst_s;
    logic [NC-1:0] exp_dv;
    logic [NC*DW-1:0] exp_pk;
    for (int i = 0; i < NC; i++) begin
      exp_dq[i] = '0;
      dv_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      edge_cnt++;
      rst_s = rst;
      #2;
      exp_dv = '0;
      if (rst_s) begin
        for (int j = sb_q.size() - 1; j >= 0; j--)
          if (sb_q[j].due >= edge_cnt) sb_q.delete(j);
        for (int i = 0; i < NC; i++) exp_dq[i] = '0;
      end else if (sb_q.size() > 0 && sb_q[0].due == edge_cnt) begin
        exp_t e;
        e = sb_q.pop_front();
        exp_dv[e.tag] = 1'b1;
        exp_dq[e.tag] = e.data;
      end
      for (int i = 0; i < NC; i++) begin
        exp_pk[i*DW +: DW] = exp_dq[i];
        if (bus.dvalid[i] === 1'b1) dv_cnt[i]++;
      end
      check("dvalid", bus.dvalid, exp_dv);
      check("dq", bus.Dq, exp_pk);
    end
  end

  // One cycle: check grant, drive requests, check RAM port, advance the model.
  task automatic step();
    logic [NC-1:0] req_v, others_v;
    logic [3:0]    exp_acq;
    bit            performed;
    int            w;
    @(negedge clk);
    exp_acq = m_own ? 4'(1 << m_owner) : 4'b0;
    check("acq", bus.acq, exp_acq);
    rst = rst_next;
    for (int i = 0; i < NC; i++) begin
      bus.rden[i] = pend[i] & p_rd[i];
      bus.wren[i] = pend[i] & p_wr[i];
      bus.Address[i*AW +: AW] = p_addr[i];
      bus.Din[i*DW +: DW]     = p_din[i];
      req_v[i] = pend[i] & (p_rd[i] | p_wr[i]);
      if (rst_next || !pend[i] || bus.acq[i]) wait_cnt[i] = 0;
      else wait_cnt[i]++;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
    #1;
    performed = m_own && req_v[m_owner];
    check("ram_wren", bus.RAMwren, performed && p_wr[m_owner]);
    check("ram_addr", bus.RAMAddress, m_own ? p_addr[m_owner] : 8'h00);
    if (bus.RAMwren === 1'b1) wren_cnt++;
    if (performed) begin
      if (p_wr[m_owner]) ref_mem[p_addr[m_owner]] = p_din[m_owner];
      else if (!rst_next) sb_q.push_back('{m_owner, ref_mem[p_addr[m_owner]], edge_cnt + 2});
      pend[m_owner] = 1'b0;
    end
    if (rst_next) begin
      m_own = 1'b0; m_last = NC - 1; m_hold = 0;
    end else if (!m_own) begin
      w = rr_next(m_last, req_v);
      if (w >= 0) begin m_own = 1'b1; m_owner = w; m_last = w; m_hold = 1; end
    end else begin
      others_v = req_v & ~NC'(1 << m_owner);
      if (!req_v[m_owner] || (m_hold == MH && others_v != '0)) begin
        w = rr_next(m_owner, others_v);
        if (w >= 0) begin m_owner = w; m_last = w; m_hold = 1; end
        else m_own = 1'b0;
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end
  endtask

  task automatic set_req(input int c, input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    pend[c] = 1'b1; p_rd[c] = rd; p_wr[c] = wr; p_addr[c] = a; p_din[c] = d;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (any_pend() && n < budget) begin step(); n++; end
    check("drain_timeout", any_pend(), 1'b0);
    repeat (3) step();
  endtask

  initial begin
    int acq_log [$];
    int f, bad, base;
    rst_next = 1'b1;
    bus.rden = '0; bus.wren = '0; bus.Address = '0; bus.Din = '0;
    m_own = 1'b0; m_owner = 0; m_last = NC - 1; m_hold = 0;
    for (int i = 0; i < NC; i++) begin
      pend[i] = 1'b0; p_rd[i] = 1'b0; p_wr[i] = 1'b0;
      p_addr[i] = '0; p_din[i] = '0; wait_cnt[i] = 0;
    end
    @(posedge clk);

    // Reset held two cycles with every core requesting; core 0 wins first.
    for (int i = 0; i < NC; i++) set_req(i, 1'b1, 1'b0, 8'(i), 8'h00);
    step(); step();
    check("rst_dvalid", bus.dvalid, 4'b0000);
    rst_next = 1'b0;
    step(); step();
    check("first_grant", bus.acq, 4'b0001);
    drain(80);

    // Single read by core 2 of a location preloaded by core 3.
    set_req(3, 1'b0, 1'b1, 8'h10, 8'hA5);
    drain(20);
    set_req(2, 1'b1, 1'b0, 8'h10, 8'h00);
    drain(20);
    check("single_read_dq2", bus.Dq[23:16], 8'hA5);

    // Fairness from reset: continuous requests rotate 0,1,2,3,0 in MAX_HOLD runs.
    rst_next = 1'b1; step(); rst_next = 1'b0;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < NC; i++) if (!pend[i]) set_req(i, 1'b1, 1'b0, 8'($urandom_range(0, 15)), 8'h00);
      step();
      acq_log.push_back(int'(bus.acq));
    end
    f = -1; bad = 0;
    foreach (acq_log[j]) if (f < 0 && acq_log[j] != 0) f = j;
    if (f < 0) bad = 1;
    else for (int j = f; j < acq_log.size(); j++)
      if (acq_log[j] != (1 << (((j - f) / MH) % NC))) bad++;
    check("fair_order", bad, 0);
    check("fair_first_owner", f >= 0 ? acq_log[f] : 0, 1);
    for (int i = 0; i < NC; i++) pend[i] = 1'b0;
    repeat (3) step();

    // Write then read-back in the next owned cycle by core 1.
    wren_cnt = 0;
    set_req(1, 1'b0, 1'b1, 8'h20, 8'h3C);
    for (int n = 0; n < 20 && pend[1]; n++) step();
    set_req(1, 1'b1, 1'b0, 8'h20, 8'h00);
    drain(20);
    check("wr_once", wren_cnt, 1);
    check("wr_rd_dq1", bus.Dq[15:8], 8'h3C);

    // Core 0 reads while core 1 waits with a write; grant moves mid-flight.
    set_req(3, 1'b0, 1'b1, 8'h05, 8'h77);
    drain(20);
    base = dv_cnt[1];
    set_req(1, 1'b0, 1'b1, 8'h30, 8'h11);
    for (int c = 0; c < 8; c++) begin
      if (!pend[0]) set_req(0, 1'b1, 1'b0, 8'h05, 8'h00);
      step();
    end
    pend[0] = 1'b0;
    drain(20);
    check("switch_dq0", bus.Dq[7:0], 8'h77);
    check("switch_no_dv1", dv_cnt[1] - base, 0);

    // Reset the cycle after a read address is issued: no return, grant dropped.
    base = dv_cnt[3];
    set_req(3, 1'b1, 1'b0, 8'h10, 8'h00);
    for (int n = 0; n < 20 && pend[3]; n++) step();
    rst_next = 1'b1; step(); rst_next = 1'b0;
    step(); step();
    check("mid_rst_no_dv", dv_cnt[3] - base, 0);
    check("mid_rst_acq", bus.acq, 4'b0000);
    check("mid_rst_dq", bus.Dq, 32'h0);

    // Random traffic with rare resets.
    max_wait = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NC; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 4) begin
          case ($urandom_range(0, 2))
            0: set_req(i, 1'b1, 1'b0, 8'($urandom_range(0, 15)), 8'($urandom));
            1: set_req(i, 1'b0, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom));
            default: set_req(i, 1'b1, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom));
          endcase
        end
      end
      rst_next = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_next = 1'b0;
    drain(200);
    check("starvation_bound", max_wait <= WAIT_BOUND, 1'b1);
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
